// File: rtl/mesh_pkg.sv
// Shared definitions for the rectangular output-stationary systolic mesh.
//   state_e    : job sequencer states
//   clog2_min1 : index width that never collapses to zero bits
//   max_int    : picks the wider of two counter widths
package mesh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN,
        DONE
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/systolic_mesh_rect_if.sv
// Job/operand/result bus of systolic_mesh_rect.
//   master : job source / result sink (drives start, operands, res_ready)
//   slave  : the mesh (drives in_ready, result row, busy, done)
interface systolic_mesh_rect_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_MAX      = 256
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = mesh_pkg::clog2_min1(ROWS);

    logic                                start_i;
    logic [KW-1:0]                       k_len_i;
    logic [ROWS-1:0][DATA_WIDTH-1:0]     west_i;
    logic [COLS-1:0][DATA_WIDTH-1:0]     north_i;
    logic                                in_valid_i;
    logic                                in_ready_o;
    logic [COLS-1:0][ACC_WIDTH-1:0]      res_data_o;
    logic [RW-1:0]                       res_row_o;
    logic                                res_valid_o;
    logic                                res_ready_i;
    logic                                busy_o;
    logic                                done_o;

    modport master (
        output start_i, k_len_i, west_i, north_i, in_valid_i, res_ready_i,
        input  in_ready_o, res_data_o, res_row_o, res_valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, k_len_i, west_i, north_i, in_valid_i, res_ready_i,
        output in_ready_o, res_data_o, res_row_o, res_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/systolic_mesh_rect_mac_pe.sv
// One processing element of the output-stationary mesh.
//   a_i/a_vld_i  : operand from the west,  forwarded east  (a_o/a_vld_o)
//   b_i/b_vld_i  : operand from the north, forwarded south (b_o/b_vld_o)
//   clr_i        : zero the accumulator (job start)
//   acc_o        : running sum of a*b over beats where both operands are valid
module mac_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic                         a_vld_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic                         b_vld_i,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic                         a_vld_o,
    output logic signed [DATA_WIDTH-1:0] b_o,
    output logic                         b_vld_o,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;

    assign prod     = a_i * b_i;
    assign prod_ext = ACC_WIDTH'(prod); // signed cast sign-extends

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_o     <= '0;
            a_vld_o <= 1'b0;
            b_o     <= '0;
            b_vld_o <= 1'b0;
            acc_o   <= '0;
        end else begin
            a_o     <= a_i;
            a_vld_o <= a_vld_i;
            b_o     <= b_i;
            b_vld_o <= b_vld_i;
            if (clr_i)
                acc_o <= '0;
            else if (a_vld_i && b_vld_i)
                acc_o <= acc_o + prod_ext; // wraps modulo 2^ACC_WIDTH
        end
    end
endmodule

// File: rtl/systolic_mesh_rect.sv
// ROWS x COLS output-stationary systolic mesh computing C = A x B.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : start/k_len job request, west/north operand beats with
//                  valid/ready, result rows with valid/ready, busy, done
// Operands are skewed internally, so the caller presents one unskewed
// column of A and row of B per accepted beat.
module systolic_mesh_rect
    import mesh_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_MAX      = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    systolic_mesh_rect_if.slave  bus
);
    localparam int KW        = $clog2(K_MAX + 1);
    localparam int RW        = clog2_min1(ROWS);
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int CW        = max_int(KW, $clog2(FLUSH_LEN + 1));

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          clr;
    logic          accept;
    logic [KW-1:0] k_clamped;

    assign k_clamped = (bus.k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len_i;
    assign accept    = bus.in_valid_i && (state_q == LOAD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (bus.start_i) begin
                clr     = 1'b1;
                k_d     = k_clamped;
                cnt_d   = '0;
                row_d   = '0;
                state_d = (k_clamped == '0) ? DRAIN : LOAD;
            end
            LOAD: if (accept) begin
                if ((cnt_q + 1'b1) == CW'(k_q)) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Long enough for the last beat to reach PE[ROWS-1][COLS-1].
            FLUSH: if (cnt_q == CW'(FLUSH_LEN - 1)) begin
                cnt_d   = '0;
                row_d   = '0;
                state_d = DRAIN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DRAIN: if (bus.res_ready_i) begin
                if (row_q == RW'(ROWS - 1)) state_d = DONE;
                else                        row_d   = row_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Mesh wiring: a_* flows west->east, b_* flows north->south.
    logic signed [DATA_WIDTH-1:0] a_h [ROWS][COLS+1];
    logic                         a_v [ROWS][COLS+1];
    logic signed [DATA_WIDTH-1:0] b_h [ROWS+1][COLS];
    logic                         b_v [ROWS+1][COLS];
    logic signed [ACC_WIDTH-1:0]  acc [ROWS][COLS];

    // Row r enters r cycles late so its operands meet the matching column.
    for (genvar r = 0; r < ROWS; r++) begin : g_wskew
        if (r == 0) begin : g_direct
            assign a_h[0][0] = bus.west_i[0];
            assign a_v[0][0] = accept;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sd_q [r];
            logic                  sv_q [r];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < r; i++) begin
                        sd_q[i] <= '0;
                        sv_q[i] <= 1'b0;
                    end
                end else begin
                    sd_q[0] <= bus.west_i[r];
                    sv_q[0] <= accept;
                    for (int i = 1; i < r; i++) begin
                        sd_q[i] <= sd_q[i-1];
                        sv_q[i] <= sv_q[i-1];
                    end
                end
            end
            assign a_h[r][0] = sd_q[r-1];
            assign a_v[r][0] = sv_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_nskew
        if (c == 0) begin : g_direct
            assign b_h[0][0] = bus.north_i[0];
            assign b_v[0][0] = accept;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sd_q [c];
            logic                  sv_q [c];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < c; i++) begin
                        sd_q[i] <= '0;
                        sv_q[i] <= 1'b0;
                    end
                end else begin
                    sd_q[0] <= bus.north_i[c];
                    sv_q[0] <= accept;
                    for (int i = 1; i < c; i++) begin
                        sd_q[i] <= sd_q[i-1];
                        sv_q[i] <= sv_q[i-1];
                    end
                end
            end
            assign b_h[0][c] = sd_q[c-1];
            assign b_v[0][c] = sv_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mac_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clr_i   (clr),
                .a_i     (a_h[r][c]),
                .a_vld_i (a_v[r][c]),
                .b_i     (b_h[r][c]),
                .b_vld_i (b_v[r][c]),
                .a_o     (a_h[r][c+1]),
                .a_vld_o (a_v[r][c+1]),
                .b_o     (b_h[r+1][c]),
                .b_vld_o (b_v[r+1][c]),
                .acc_o   (acc[r][c])
            );
        end
    end

    // Result row is forced to zero outside DRAIN so nothing stale leaks out.
    logic [COLS-1:0][ACC_WIDTH-1:0] res_data;
    always_comb begin
        res_data = '0;
        if (state_q == DRAIN)
            for (int c = 0; c < COLS; c++) res_data[c] = acc[row_q][c];
    end

    assign bus.res_data_o  = res_data;
    assign bus.res_row_o   = (state_q == DRAIN) ? row_q : '0;
    assign bus.res_valid_o = (state_q == DRAIN);
    assign bus.in_ready_o  = (state_q == LOAD);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);
endmodule

// File: tb/tb_systolic_mesh_rect.sv
module tb_systolic_mesh_rect;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_mesh_rect_if #(.ROWS(2), .COLS(2), .DATA_WIDTH(16), .ACC_WIDTH(40), .K_MAX(4)) bus ();
    systolic_mesh_rect_if #(.ROWS(2), .COLS(2), .DATA_WIDTH(8),  .ACC_WIDTH(16), .K_MAX(4)) bus8 ();

    systolic_mesh_rect #(.ROWS(2), .COLS(2), .DATA_WIDTH(16), .ACC_WIDTH(40), .K_MAX(4)) dut (
        .clk_i (clk), .rst_i (rst), .bus (bus.slave));
    systolic_mesh_rect #(.ROWS(2), .COLS(2), .DATA_WIDTH(8), .ACC_WIDTH(16), .K_MAX(4)) dut8 (
        .clk_i (clk), .rst_i (rst), .bus (bus8.slave));

    typedef struct {
        int kdrv;     // value driven on k_len_i
        int k;        // beats actually fed (after clamp)
        int gap;      // bubble cycles between beats
        int stall;    // hold res_ready low 3 cycles on row 0
        int a [2][4];
        int b [4][2];
        int c [2][2];
    } vec_t;

    vec_t tbl [6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, longint'(bus.in_ready_o), 0);
        chk({tag, "_res_valid"}, longint'(bus.res_valid_o), 0);
        chk({tag, "_busy"}, longint'(bus.busy_o), 0);
        chk({tag, "_done"}, longint'(bus.done_o), 0);
        chk({tag, "_res_row"}, longint'(bus.res_row_o), 0);
        chk({tag, "_res_data"}, longint'(bus.res_data_o != '0), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int fl;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.k_len_i = 3'(v.kdrv);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("busy_load", longint'(bus.busy_o), 1);
        for (int j = 0; j < v.k; j++) begin
            if (j > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    bus.in_valid_i = 1'b0;
                    @(negedge clk);
                end
            end
            chk("ready_load", longint'(bus.in_ready_o), 1);
            bus.west_i[0]  = 16'(v.a[0][j]);
            bus.west_i[1]  = 16'(v.a[1][j]);
            bus.north_i[0] = 16'(v.b[j][0]);
            bus.north_i[1] = 16'(v.b[j][1]);
            bus.in_valid_i = 1'b1;
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        chk("ready_flush", longint'(bus.in_ready_o), 0);
        fl = 0;
        while (!bus.res_valid_o && fl < 20) begin
            fl++;
            @(negedge clk);
        end
        chk("flush_len", fl, 3);
        for (int r = 0; r < 2; r++) begin
            chk("res_valid", longint'(bus.res_valid_o), 1);
            chk("res_row", longint'(bus.res_row_o), r);
            for (int c = 0; c < 2; c++)
                chk($sformatf("res_r%0d_c%0d", r, c), longint'($signed(bus.res_data_o[c])), longint'(v.c[r][c]));
            if (v.stall != 0 && r == 0) begin
                bus.res_ready_i = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_valid", longint'(bus.res_valid_o), 1);
                    chk("stall_row", longint'(bus.res_row_o), 0);
                    chk("stall_c0", longint'($signed(bus.res_data_o[0])), longint'(v.c[0][0]));
                    chk("stall_c1", longint'($signed(bus.res_data_o[1])), longint'(v.c[0][1]));
                end
                bus.res_ready_i = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", longint'(bus.done_o), 1);
        chk("busy_done", longint'(bus.busy_o), 1);
        @(negedge clk);
        chk("done_low", longint'(bus.done_o), 0);
        chk("busy_idle", longint'(bus.busy_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int fl;
        tbl[0] = '{kdrv:2, k:2, gap:0, stall:0,
                   a:'{'{1,2,0,0}, '{3,4,0,0}},
                   b:'{'{5,6}, '{7,8}, '{0,0}, '{0,0}},
                   c:'{'{19,22}, '{43,50}}};
        tbl[1] = tbl[0];
        tbl[1].gap = 3;
        tbl[2] = tbl[0];
        tbl[2].stall = 1;
        tbl[3] = '{kdrv:3, k:3, gap:1, stall:0,
                   a:'{'{1,-2,3,0}, '{0,5,-1,0}},
                   b:'{'{2,0}, '{1,-3}, '{4,1}, '{0,0}},
                   c:'{'{12,9}, '{1,-16}}};
        tbl[4] = '{kdrv:1, k:1, gap:0, stall:0,
                   a:'{'{-7,0,0,0}, '{100,0,0,0}},
                   b:'{'{3,-2}, '{0,0}, '{0,0}, '{0,0}},
                   c:'{'{-21,14}, '{300,-200}}};
        // k_len 6 exceeds K_MAX=4: only 4 beats are accepted
        tbl[5] = '{kdrv:6, k:4, gap:0, stall:0,
                   a:'{'{1,1,1,1}, '{2,2,2,2}},
                   b:'{'{1,2}, '{3,4}, '{5,6}, '{7,8}},
                   c:'{'{16,20}, '{32,40}}};

        bus.start_i = 0; bus.k_len_i = '0; bus.west_i = '0; bus.north_i = '0;
        bus.in_valid_i = 0; bus.res_ready_i = 1;
        bus8.start_i = 0; bus8.k_len_i = '0; bus8.west_i = '0; bus8.north_i = '0;
        bus8.in_valid_i = 0; bus8.res_ready_i = 1;

        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // k_len 0: straight to DRAIN with zero rows; start during DRAIN ignored
        @(negedge clk);
        bus.start_i = 1'b1; bus.k_len_i = 3'd0;
        @(negedge clk);
        chk("k0_in_ready", longint'(bus.in_ready_o), 0);
        chk("k0_valid_r0", longint'(bus.res_valid_o), 1);
        chk("k0_row0", longint'(bus.res_row_o), 0);
        chk("k0_data_r0", longint'(bus.res_data_o != '0), 0);
        bus.k_len_i = 3'd2;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("k0_row1", longint'(bus.res_row_o), 1);
        chk("k0_data_r1", longint'(bus.res_data_o != '0), 0);
        @(negedge clk);
        chk("k0_done", longint'(bus.done_o), 1);
        @(negedge clk);
        chk("k0_idle_busy", longint'(bus.busy_o), 0);
        chk("k0_no_load", longint'(bus.in_ready_o), 0);

        // reset mid-LOAD discards the job
        @(negedge clk);
        bus.start_i = 1'b1; bus.k_len_i = 3'd2;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.west_i[0] = 16'd9; bus.west_i[1] = 16'd9;
        bus.north_i[0] = 16'd9; bus.north_i[1] = 16'd9;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_vec(tbl[0]);

        // narrow instance: (-128)*(-128)*3 = 49152 wraps to 0xC000 in 16 bits
        @(negedge clk);
        bus8.start_i = 1'b1; bus8.k_len_i = 3'd3;
        @(negedge clk);
        bus8.start_i = 1'b0;
        bus8.west_i = {8'h80, 8'h80};
        bus8.north_i = {8'h80, 8'h80};
        bus8.in_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus8.in_valid_i = 1'b0;
        fl = 0;
        while (!bus8.res_valid_o && fl < 20) begin
            fl++;
            @(negedge clk);
        end
        chk("wrap_flush_len", fl, 3);
        for (int r = 0; r < 2; r++) begin
            chk("wrap_row", longint'(bus8.res_row_o), r);
            for (int c = 0; c < 2; c++)
                chk($sformatf("wrap_r%0d_c%0d", r, c), longint'(bus8.res_data_o[c]), longint'(16'hC000));
            @(negedge clk);
        end
        chk("wrap_done", longint'(bus8.done_o), 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_mesh_rect.md
SYSTOLIC_MESH_RECT -- requirements
Module: systolic_mesh_rect

Interface
REQ-001 SHALL have parameter ROWS, default 4, mesh row count (>=1).
REQ-002 SHALL have parameter COLS, default 4, mesh column count (>=1, independent of ROWS).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width (>= 2*DATA_WIDTH).
REQ-005 SHALL have parameter K_MAX, default 256, maximum reduction length.
REQ-006 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start_i  input  1  job start pulse.
REQ-009 SHALL have port k_len_i  input  $clog2(K_MAX+1)  reduction length, sampled with start_i.
REQ-010 SHALL have port west_i  input  [ROWS] x DATA_WIDTH  A column beat, element r to row r.
REQ-011 SHALL have port north_i  input  [COLS] x DATA_WIDTH  B row beat, element c to column c.
REQ-012 SHALL have port in_valid_i  input  1  operand beat valid.
REQ-013 SHALL have port in_ready_o  output  1  operand beat accepted when in_valid_i & in_ready_o.
REQ-014 SHALL have port res_data_o  output  [COLS] x ACC_WIDTH  one result row.
REQ-015 SHALL have port res_row_o  output  $clog2(ROWS) (min 1)  index of presented row.
REQ-016 SHALL have port res_valid_o  output  1  result row valid.
REQ-017 SHALL have port res_ready_i  input  1  result row consumed when res_valid_o & res_ready_i.
REQ-018 SHALL have port busy_o  output  1  high in any state except IDLE.
REQ-019 SHALL have port done_o  output  1  one-cycle pulse at job end.

Function
REQ-020 SHALL compute C = A x B, A ROWS x K, B K x COLS, output-stationary: PE[r][c] holds C[r][c].
REQ-021 SHALL skew inputs internally: west_i[r] delayed r cycles, north_i[c] delayed c cycles, valid bit travelling with each operand.
REQ-022 Each PE SHALL register and forward operand+valid east/south with 1-cycle hop latency, and accumulate only when both arriving operands are valid.
REQ-023 Product SHALL be full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; accumulation wraps modulo 2^ACC_WIDTH, no saturation.
REQ-024 FSM states SHALL be IDLE, LOAD, FLUSH, DRAIN, DONE.
REQ-025 IDLE->LOAD on start_i with k_len_i>0; IDLE->DRAIN on start_i with k_len_i==0; both clear all accumulators and latch k_len_i.
REQ-026 in_ready_o SHALL be high only in LOAD; LOAD->FLUSH on the cycle the K-th beat is accepted.
REQ-027 Cycles with in_valid_i low in LOAD SHALL inject invalid bubbles, leaving results unaffected.
REQ-028 FLUSH SHALL last exactly ROWS+COLS-1 cycles, then enter DRAIN.
REQ-029 DRAIN SHALL present rows 0..ROWS-1 in order; res_data_o/res_row_o stable while res_valid_o & !res_ready_i.
REQ-030 DRAIN->DONE on handshake of row ROWS-1; done_o high for the single DONE cycle; DONE->IDLE unconditionally.
REQ-031 start_i outside IDLE SHALL be ignored; k_len_i > K_MAX SHALL be clamped to K_MAX.

Reset
REQ-032 rst_i SHALL asynchronously force IDLE, clear accumulators, skew and pipeline registers (data and valid), counters.
REQ-033 During/after reset: in_ready_o, res_valid_o, busy_o, done_o = 0; res_data_o, res_row_o = 0.
REQ-034 Reset mid-job SHALL discard the job; the next job after release SHALL compute correctly.

Structure
REQ-035 Package mesh_pkg SHALL hold the FSM state enum and width helper constants/functions.
REQ-036 One sub-module mac_pe SHALL implement a PE; the mesh instantiates ROWS x COLS of them via generate.

Verification
REQ-037 2x2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], K=2, res_ready_i=1 -> rows [19,22],[43,50], done_o pulse once, busy_o then low.
REQ-038 Same job, in_valid_i low for 3 cycles between beats -> identical results; FLUSH still ROWS+COLS-1 cycles.
REQ-039 res_ready_i low 3 cycles on row 0 -> res_data_o/res_row_o unchanged throughout, no row skipped.
REQ-040 DATA_WIDTH=8, ACC_WIDTH=16, a=b=-128, K=3 -> every element 0xC000 (-16384) by wrap.
REQ-041 k_len_i=0 -> no in_ready_o, ROWS all-zero rows, done_o; start_i during DRAIN ignored.
REQ-042 rst_i asserted mid-LOAD -> all outputs 0 immediately, IDLE; subsequent REQ-037 job correct.
